// File: rtl/store_commit_buffer.sv
// Post-commit store buffer: takes up to two committed stores per cycle in
// program order, holds them in a circular FIFO and drains them one at a time
// to the data-memory port. Also reports commit credits and a word-address
// conflict flag for the load pipe.
module store_commit_buffer #(
  parameter int STB_ENTRIES   = 8,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_DATA_BITS = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [1:0]                        commit_vals,
  input  logic [2*CPU_ADDR_BITS-1:0]        commit_addrs,
  input  logic [2*CPU_DATA_BITS-1:0]        commit_data,
  input  logic [7:0]                        commit_strb,
  output logic [1:0]                        stb_rdy,
  output logic [$clog2(STB_ENTRIES):0]      stb_count,
  output logic                              stb_empty,
  output logic                              stb_overflow,
  output logic                              mem_req_val,
  output logic [CPU_ADDR_BITS-1:0]          mem_req_addr,
  output logic [CPU_DATA_BITS-1:0]          mem_req_data,
  output logic [3:0]                        mem_req_strb,
  input  logic                              mem_req_rdy,
  input  logic [CPU_ADDR_BITS-1:0]          ld_addr,
  output logic                              ld_conflict
);

  localparam int PTR_W = $clog2(STB_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  logic [STB_ENTRIES-1:0]   r_valid;
  logic [CPU_ADDR_BITS-1:0] r_addr [STB_ENTRIES];
  logic [CPU_DATA_BITS-1:0] r_data [STB_ENTRIES];
  logic [3:0]               r_strb [STB_ENTRIES];
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [CNT_W-1:0]         r_count;
  logic                     r_overflow;

  logic [CNT_W-1:0]         w_free;
  logic [1:0]               w_reqCnt;
  logic [1:0]               w_acceptCnt;
  logic [PTR_W-1:0]         w_tailNext;
  logic [CPU_ADDR_BITS-1:0] w_firstAddr;
  logic [CPU_DATA_BITS-1:0] w_firstData;
  logic [3:0]               w_firstStrb;
  logic                     w_memVal;
  logic                     w_pop;
  logic                     w_conflict;
  logic                     w_unusedBits;

  // Only the word address takes part in the conflict check.
  assign w_unusedBits = ^ld_addr[1:0];

  // Credit and push decode. Credits come from the registered count only, so a
  // same-cycle pop never adds a grant. The first granted slot always takes the
  // oldest valid lane, which compacts a lone lane-1 store onto the tail.
  always_comb begin
    w_free      = CNT_W'(STB_ENTRIES) - r_count;
    w_reqCnt    = 2'(commit_vals[0]) + 2'(commit_vals[1]);
    w_acceptCnt = 2'd0;
    if (w_free >= CNT_W'(2)) begin
      w_acceptCnt = w_reqCnt;
    end else if (w_free == CNT_W'(1)) begin
      w_acceptCnt = (w_reqCnt != 2'd0) ? 2'd1 : 2'd0;
    end
    w_tailNext  = r_tail + PTR_W'(1);
    w_firstAddr = commit_vals[0] ? commit_addrs[0 +: CPU_ADDR_BITS]
                                 : commit_addrs[CPU_ADDR_BITS +: CPU_ADDR_BITS];
    w_firstData = commit_vals[0] ? commit_data[0 +: CPU_DATA_BITS]
                                 : commit_data[CPU_DATA_BITS +: CPU_DATA_BITS];
    w_firstStrb = commit_vals[0] ? commit_strb[3:0] : commit_strb[7:4];
  end

  // Head entry drives the memory request; payload reads zero while empty.
  always_comb begin
    w_memVal     = r_valid[r_head];
    w_pop        = w_memVal && mem_req_rdy;
    mem_req_addr = w_memVal ? r_addr[r_head] : '0;
    mem_req_data = w_memVal ? r_data[r_head] : '0;
    mem_req_strb = w_memVal ? r_strb[r_head] : 4'h0;
  end

  // Word-address match against every valid entry, no forwarding.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < STB_ENTRIES; i++) begin
      if (r_valid[i] && (r_addr[i][CPU_ADDR_BITS-1:2] == ld_addr[CPU_ADDR_BITS-1:2])) begin
        w_conflict = 1'b1;
      end
    end
  end

  // Control state: valid bits, pointers, occupancy and the sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_acceptCnt != 2'd0) begin
        r_valid[r_tail] <= 1'b1;
      end
      if (w_acceptCnt == 2'd2) begin
        r_valid[w_tailNext] <= 1'b1;
      end
      r_tail  <= r_tail + PTR_W'(w_acceptCnt);
      r_count <= r_count + CNT_W'(w_acceptCnt) - CNT_W'(w_pop);
      if (w_acceptCnt != w_reqCnt) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Entry payload storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (w_acceptCnt != 2'd0) begin
      r_addr[r_tail] <= w_firstAddr;
      r_data[r_tail] <= w_firstData;
      r_strb[r_tail] <= w_firstStrb;
    end
    if (w_acceptCnt == 2'd2) begin
      r_addr[w_tailNext] <= commit_addrs[CPU_ADDR_BITS +: CPU_ADDR_BITS];
      r_data[w_tailNext] <= commit_data[CPU_DATA_BITS +: CPU_DATA_BITS];
      r_strb[w_tailNext] <= commit_strb[7:4];
    end
  end

  // Committed stores must never arrive alongside a pipeline flush.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(flush && (commit_vals != 2'b00)));
    end
  end

  assign stb_rdy      = {(w_free >= CNT_W'(2)), (w_free >= CNT_W'(1))};
  assign stb_count    = r_count;
  assign stb_empty    = (r_count == '0);
  assign stb_overflow = r_overflow;
  assign mem_req_val  = w_memVal;
  assign ld_conflict  = w_conflict;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed commits push their
// expected memory requests into a scoreboard queue; a monitor pops and
// compares each accepted memory request. Status outputs are checked inline.
module tb_store_commit_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  commit_vals;
  logic [63:0] commit_addrs;
  logic [63:0] commit_data;
  logic [7:0]  commit_strb;
  logic [1:0]  stb_rdy;
  logic [3:0]  stb_count;
  logic        stb_empty;
  logic        stb_overflow;
  logic        mem_req_val;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_strb;
  logic        mem_req_rdy;
  logic [31:0] ld_addr;
  logic        ld_conflict;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } req_t;

  req_t expQ[$];
  int   nChecks = 0;
  int   nPassed = 0;

  store_commit_buffer #(
    .STB_ENTRIES(8),
    .CPU_ADDR_BITS(32),
    .CPU_DATA_BITS(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .commit_vals(commit_vals),
    .commit_addrs(commit_addrs),
    .commit_data(commit_data),
    .commit_strb(commit_strb),
    .stb_rdy(stb_rdy),
    .stb_count(stb_count),
    .stb_empty(stb_empty),
    .stb_overflow(stb_overflow),
    .mem_req_val(mem_req_val),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_strb(mem_req_strb),
    .mem_req_rdy(mem_req_rdy),
    .ld_addr(ld_addr),
    .ld_conflict(ld_conflict)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, reports and tallies.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) begin
      nPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of commit lanes; lanes set in expMask are the ones the
  // buffer should accept, and their requests are queued as expected output.
  task automatic applyStimulus(input logic [1:0] vals, input logic [1:0] expMask,
                               input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                               input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    commit_vals  = vals;
    commit_addrs = {a1, a0};
    commit_data  = {d1, d0};
    commit_strb  = {s1, s0};
    if (expMask[0]) expQ.push_back('{addr: a0, data: d0, strb: s0});
    if (expMask[1]) expQ.push_back('{addr: a1, data: d1, strb: s1});
  endtask

  // Advance to just after the next rising edge and retire commit lanes.
  task automatic step();
    @(posedge clk);
    #1;
    commit_vals = 2'b00;
  endtask

  // Monitor: every accepted memory request must match the scoreboard head.
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_req_val && mem_req_rdy) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_mem_req", {32'h0, mem_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("mem_req_addr", {32'h0, mem_req_addr}, {32'h0, e.addr});
          checkOutput("mem_req_data", {32'h0, mem_req_data}, {32'h0, e.data});
          checkOutput("mem_req_strb", {60'h0, mem_req_strb}, {60'h0, e.strb});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    commit_vals  = 2'b00;
    commit_addrs = '0;
    commit_data  = '0;
    commit_strb  = '0;
    mem_req_rdy  = 1'b0;
    ld_addr      = '0;

    // Reset held for two edges.
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_empty", {63'h0, stb_empty}, 64'd1);
    checkOutput("reset_rdy", {62'h0, stb_rdy}, 64'd3);
    checkOutput("reset_count", {60'h0, stb_count}, 64'd0);
    checkOutput("reset_memval", {63'h0, mem_req_val}, 64'd0);
    checkOutput("reset_overflow", {63'h0, stb_overflow}, 64'd0);
    checkOutput("reset_conflict", {63'h0, ld_conflict}, 64'd0);
    checkOutput("reset_memaddr", {32'h0, mem_req_addr}, 64'd0);

    // Dual push, ordered drain.
    mem_req_rdy = 1'b1;
    applyStimulus(2'b11, 2'b11, 32'h100, 32'hAAAA_0001, 4'hF, 32'h104, 32'hBBBB_0002, 4'hF);
    step();
    checkOutput("dual_count2", {60'h0, stb_count}, 64'd2);
    checkOutput("dual_first_addr", {32'h0, mem_req_addr}, 64'h100);
    step();
    checkOutput("dual_count1", {60'h0, stb_count}, 64'd1);
    checkOutput("dual_second_addr", {32'h0, mem_req_addr}, 64'h104);
    step();
    checkOutput("dual_count0", {60'h0, stb_count}, 64'd0);
    checkOutput("dual_empty", {63'h0, stb_empty}, 64'd1);

    // Lone lane-1 store compacted to tail and held under stall.
    mem_req_rdy = 1'b0;
    applyStimulus(2'b10, 2'b10, 32'hDEAD_0000, 32'h0, 4'h0, 32'h200, 32'h1234_5678, 4'h3);
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_addr", {32'h0, mem_req_addr}, 64'h200);
      checkOutput("stall_strb", {60'h0, mem_req_strb}, 64'h3);
      checkOutput("stall_count", {60'h0, stb_count}, 64'd1);
      if (i < 2) step();
    end
    mem_req_rdy = 1'b1;
    step();
    mem_req_rdy = 1'b0;
    checkOutput("stall_popped", {60'h0, stb_count}, 64'd0);

    // Fill from head/tail = 3: dual pushes wrap across entries 7 and 0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 2'b11,
                    32'h400 + 32'(16 * i), 32'h4000_0000 + 32'(2 * i), 4'hF,
                    32'h404 + 32'(16 * i), 32'h4000_0001 + 32'(2 * i), 4'hC);
      step();
    end
    checkOutput("full_count", {60'h0, stb_count}, 64'd8);
    checkOutput("full_rdy", {62'h0, stb_rdy}, 64'd0);
    mem_req_rdy = 1'b1;
    step();
    mem_req_rdy = 1'b0;
    checkOutput("nearfull_count", {60'h0, stb_count}, 64'd7);
    checkOutput("nearfull_rdy", {62'h0, stb_rdy}, 64'd1);
    applyStimulus(2'b11, 2'b01, 32'h480, 32'h4800_0000, 4'hF, 32'h484, 32'h4840_0000, 4'hF);
    step();
    checkOutput("overflow_count", {60'h0, stb_count}, 64'd8);
    checkOutput("overflow_flag", {63'h0, stb_overflow}, 64'd1);
    checkOutput("overflow_rdy", {62'h0, stb_rdy}, 64'd0);
    mem_req_rdy = 1'b1;
    repeat (8) step();
    mem_req_rdy = 1'b0;
    checkOutput("fill_drained", {60'h0, stb_count}, 64'd0);
    checkOutput("overflow_sticky", {63'h0, stb_overflow}, 64'd1);

    // Load conflict on word address; same-cycle push is not visible.
    ld_addr = 32'h302;
    applyStimulus(2'b01, 2'b01, 32'h300, 32'h3000_3000, 4'hF, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("conflict_same_cycle", {63'h0, ld_conflict}, 64'd0);
    step();
    checkOutput("conflict_hit", {63'h0, ld_conflict}, 64'd1);
    ld_addr = 32'h304;
    #1;
    checkOutput("conflict_other_word", {63'h0, ld_conflict}, 64'd0);
    ld_addr = 32'h302;
    mem_req_rdy = 1'b1;
    step();
    mem_req_rdy = 1'b0;
    #1;
    checkOutput("conflict_after_pop", {63'h0, ld_conflict}, 64'd0);

    // Flush leaves buffered stores intact; all of them still drain.
    applyStimulus(2'b11, 2'b11, 32'h500, 32'h5000_0000, 4'h1, 32'h504, 32'h5040_0000, 4'h2);
    step();
    applyStimulus(2'b01, 2'b01, 32'h508, 32'h5080_0000, 4'h4, 32'h0, 32'h0, 4'h0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_count", {60'h0, stb_count}, 64'd3);
    mem_req_rdy = 1'b1;
    repeat (3) step();
    mem_req_rdy = 1'b0;
    checkOutput("flush_drained", {60'h0, stb_count}, 64'd0);

    // Reset mid-drain discards the remaining stores.
    applyStimulus(2'b11, 2'b11, 32'h600, 32'h6000_0000, 4'hF, 32'h604, 32'h6040_0000, 4'hF);
    step();
    applyStimulus(2'b01, 2'b01, 32'h608, 32'h6080_0000, 4'hF, 32'h0, 32'h0, 4'h0);
    step();
    mem_req_rdy = 1'b1;
    step();
    checkOutput("middrain_count", {60'h0, stb_count}, 64'd2);
    rst = 1'b1;
    expQ.delete();
    step();
    rst = 1'b0;
    checkOutput("rst_count", {60'h0, stb_count}, 64'd0);
    checkOutput("rst_memval", {63'h0, mem_req_val}, 64'd0);
    checkOutput("rst_overflow", {63'h0, stb_overflow}, 64'd0);
    checkOutput("rst_rdy", {62'h0, stb_rdy}, 64'd3);
    step();
    checkOutput("empty_ignores_rdy", {60'h0, stb_count}, 64'd0);
    mem_req_rdy = 1'b0;
    step();
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

- Post-commit store buffer between ROB commit and the data-memory port.
- Accepts up to two architecturally committed stores per cycle in program order, holds them in a circular FIFO, and drains them to memory one at a time over a valid/ready handshake.
- Gives back-pressure credits to commit and a word-address conflict check to the load pipe.
- Committed stores are architectural state, so the pipeline flush never discards buffer contents.

## Interface

Parameters:

- STB_ENTRIES, 8, buffer depth; power of two, ≥ 2.
- CPU_ADDR_BITS, 32, address width, from uarch_pkg.
- CPU_DATA_BITS, 32, data width, from uarch_pkg.

Ports:

- clk  in  1  clock. One clock domain; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush. Has no effect on buffer contents; used only for the assertion described under Operation.
- commit_vals  in  2  per-lane committed store valid; lane 0 is older.
- commit_addrs  in  2×CPU_ADDR_BITS  byte address per lane.
- commit_data  in  2×CPU_DATA_BITS  store data per lane, already lane-aligned.
- commit_strb  in  2×4  byte enables per lane.
- stb_rdy  out  2  bit 0: at least 1 free slot; bit 1: at least 2 free slots.
- stb_count  out  $clog2(STB_ENTRIES)+1  number of occupied entries.
- stb_empty  out  1  stb_count == 0.
- stb_overflow  out  1  sticky error flag; cleared only by rst.
- mem_req_val  out  1  head entry valid.
- mem_req_addr  out  CPU_ADDR_BITS  head address.
- mem_req_data  out  CPU_DATA_BITS  head data.
- mem_req_strb  out  4  head byte enables.
- mem_req_rdy  in  1  memory accepts this cycle.
- ld_addr  in  CPU_ADDR_BITS  load probe address.
- ld_conflict  out  1  some valid entry has the same word address as ld_addr.

## Operation

Storage and pointers:

- Storage is STB_ENTRIES entries of {valid, addr, data, strb}.
- head and tail pointers are $clog2(STB_ENTRIES) bits wide and wrap naturally.
- count is held in a separate register.

Push (commit side):

- Lanes are compacted. Exactly one valid lane writes to tail, whichever lane it is.
- When both lanes are valid, lane 0 writes to tail and lane 1 to tail+1.
- push_cnt = popcount(commit_vals).

Pop (memory side):

- pop = mem_req_val && mem_req_rdy.
- On pop: the head entry is invalidated and head advances by 1.

Count update:

- count_next = count + push_cnt − pop.
- Simultaneous push and pop in the same cycle is legal.

Credits and overflow:

- stb_rdy is derived from registered count only. It does not include the same-cycle pop, so credits are conservative.
- The ROB must not present more valid lanes than stb_rdy grants.
- A lane exceeding the granted credit is dropped (not written), and stb_overflow is set.

Memory request:

- mem_req_* are driven combinationally from the head entry.
- The payload is held stable while mem_req_val && !mem_req_rdy.

Load conflict check:

- ld_conflict = OR over all entries of valid && (addr[CPU_ADDR_BITS-1:2] == ld_addr[CPU_ADDR_BITS-1:2]).
- Combinational, with no forwarding. The load pipe stalls the load while ld_conflict is high.

Flush:

- flush has no effect on the buffer.
- Assertion: commit_vals must be 0 in any cycle where flush is 1.

Reset (rst=1 at a clock edge):

- All valid bits, head, tail and count are cleared, along with stb_overflow.
- Outputs after reset: stb_rdy=2'b11, stb_count=0, stb_empty=1, mem_req_val=0, ld_conflict=0.
- mem_req_addr/data/strb read 0 while empty.
- Reset mid-drain discards pending stores. This is accepted only at power-on or a full-system reset.

## Timing

Latency:

- Commit at edge N makes the entry visible on mem_req_val and ld_conflict from cycle N+1.
- Pop at edge N makes the next entry visible in cycle N+1.
- Sustained drain throughput is 1 store per cycle.

Full buffer (count == STB_ENTRIES):

- stb_rdy = 00.
- A pop in that cycle frees a slot, but stb_rdy rises only in the following cycle.

Nearly full (count == STB_ENTRIES−1):

- stb_rdy = 01; only one lane is granted.

Empty buffer:

- mem_req_val = 0; mem_req_rdy is ignored.
- There is no bypass: a store pushed into an empty buffer is presented one cycle later.

Pointer wrap:

- tail+1 wraps modulo STB_ENTRIES.
- Dual push at tail = STB_ENTRIES−1 writes entries 7 and 0 (for depth 8).

Simultaneous events:

- Push to an entry while the same entry is being popped cannot occur: when count == STB_ENTRIES, credits are 0.
- A load probe in the same cycle as a push of a matching store does not see it. That store becomes visible next cycle, which is safe because the store is older and already committed.

## Test plan

- **Reset:** assert rst 2 cycles, then release. Required: stb_empty=1, stb_rdy=11, stb_count=0, mem_req_val=0, stb_overflow=0.
- **Dual push, ordered drain:**
  - Stimulus: commit_vals=11 with addrs 0x100 and 0x104; data 0xAAAA_0001 and 0xBBBB_0002; strb 4'hF; mem_req_rdy=1.
  - Required: 0x100 appears on mem_req in the cycle after commit, then 0x104; stb_count goes 2→1→0.
- **Lane compaction and stall:**
  - Stimulus: commit_vals=10 with addr 0x200; mem_req_rdy=0 for 3 cycles.
  - Required: entry written at tail; mem_req_addr=0x200 held stable for all 3 cycles; pop on the first rdy cycle.
- **Fill and wrap (depth 8):**
  - Stimulus: 4 dual pushes with rdy=0.
  - Required: count=8, stb_rdy=00.
  - Stimulus: then 1 pop.
  - Required: count=7, with stb_rdy=01 on the next cycle.
  - Stimulus: then a dual push offered.
  - Required: only lane 0 is written; stb_overflow=1; tail wraps to 0.
- **Load conflict:**
  - Stimulus: buffer holds 0x300; probe ld_addr=0x302.
  - Required: ld_conflict=1.
  - Stimulus: probe 0x304.
  - Required: ld_conflict=0.
  - Stimulus: 0x300 pops.
  - Required: ld_conflict=0 the next cycle for 0x302.
- **Flush and reset:**
  - Stimulus: flush pulse with 3 entries buffered.
  - Required: count stays 3 and all 3 drain.
  - Stimulus: rst asserted mid-drain.
  - Required: count=0 and mem_req_val=0 on the next cycle.
